enc_round_scheduler: RTL

Round-robin scheduler that shares one 8-bit encryption round datapath among `NREQ` requesters and iterates it for `ROUNDS` rounds per request. It sits between the requesting byte sources and the downstream consumer. Each requester offers a byte and a key over a valid/ready handshake. The block arbitrates, sequences the rounds and key schedule through a single round unit, and returns the ciphertext tagged with the requester index. `ROUNDS=1` reproduces the single-pass byte cipher exactly.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/enc_round.sv | 28 ++
 rtl/enc_round_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the round-iterated byte cipher scheduler:
// FSM state encoding, the round expansion bit-map and the key rotation helper.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    // Source bit of n[3:0] for each expansion bit, index 0 = e[0] ... index 7 = e[7].
    // Read top-down this gives e = {n3,n0,n1,n2,n1,n3,n2,n0}.
    localparam logic [1:0] EXP_MAP [8] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [7:0] rotl8(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] doubled;
        doubled = {value, value} << amount;
        return doubled[15:8];
    endfunction

endpackage

// File: rtl/enc_round.sv
// Combinational round function F(n, k): expand, key-mix, nibble-sum and
// fold the sum into the upper nibble. Swap and key schedule live in the caller.
module enc_round
    import enc_pkg::*;
(
    input  logic [7:0] n,
    input  logic [7:0] k,
    output logic [7:0] y
);

    logic [7:0] expanded;
    logic [7:0] mixed;
    logic [3:0] sum;

    // NOTE: every variable written here gets a value before any branch or loop,
    // so no path can leave it holding its old value and infer a latch.
    always_comb begin
        expanded = '0;
        for (int i = 0; i < 8; i++) begin
            expanded[i] = n[EXP_MAP[i]];
        end
        mixed = expanded ^ k;
        // Four-bit sum: the carry out of the nibble is intentionally dropped.
        sum = mixed[7:4] + mixed[3:0] + {3'b000, k[0]};
        y   = {n[7:4] ^ sum, n[3:0]};
    end

endmodule

// File: rtl/enc_round_scheduler.sv
// Round-robin front end sharing one enc_round datapath among NREQ requesters,
// iterating ROUNDS rounds per request and returning an id-tagged result.
module enc_round_scheduler
    import enc_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ROUNDS = 4,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic [NREQ*8-1:0]   req_key,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [7:0]          resp_data,
    output logic [IDW-1:0]      resp_id,
    output logic                busy
);

    localparam logic [2:0] LAST_RC = 3'(ROUNDS - 1);

    state_t         state, state_d;
    logic [IDW-1:0] ptr, ptr_d;
    logic [2:0]     rc, rc_d;
    logic [7:0]     n_q, n_d;
    logic [7:0]     key_q, key_d;
    logic [IDW-1:0] id_q, id_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic [7:0]     grant_data;
    logic [7:0]     grant_key;

    logic [7:0]     round_key;
    logic [7:0]     round_y;

    assign round_key = rotl8(key_q, rc);

    enc_round u_round (
        .n (n_q),
        .k (round_key),
        .y (round_y)
    );

    // Search upward from ptr, wrapping; the first asserted valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        grant_key   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
                grant_data  = req_data[{cand, 3'b000} +: 8];
                grant_key   = req_key[{cand, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        rc_d      = rc;
        n_d       = n_q;
        key_d     = key_q;
        id_d      = id_q;
        req_ready = '0;

        case (state)
            IDLE: begin
                // Gated by reset so no handshake can complete in a reset cycle.
                if (grant_found && !reset) begin
                    req_ready = NREQ'(1) << grant_idx;
                    n_d       = grant_data;
                    key_d     = grant_key;
                    id_d      = grant_idx;
                    rc_d      = '0;
                    state_d   = ROUND;
                end
            end
            ROUND: begin
                if (rc == LAST_RC) begin
                    n_d     = round_y;
                    state_d = DONE;
                end else begin
                    n_d  = {round_y[3:0], round_y[7:4]};
                    rc_d = rc + 3'd1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            rc    <= '0;
            n_q   <= '0;
            key_q <= '0;
            id_q  <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            rc    <= rc_d;
            n_q   <= n_d;
            key_q <= key_d;
            id_q  <= id_d;
        end
    end

    assign resp_valid = (state == DONE);
    assign resp_data  = n_q;
    assign resp_id    = id_q;
    assign busy       = (state != IDLE);

endmodule
